// File: rtl/laser_pkg.sv
// Shared definitions for the laser pulse generator and its safety monitor:
// FSM encodings, timebase default and nominal timing constants.
package laser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } laser_state_t;

  localparam int TICK_DIV_DEFAULT = 8;
  localparam int CNT_W_DEFAULT    = 32;

  // Nominal 25 ms period and pulse-width window, in clk/8 ticks, as seen by the monitor
  localparam logic [31:0] NOM_PERIOD_TICKS = 32'h0001_312D;
  localparam logic [31:0] NOM_WIDTH_MIN    = 32'h0000_0307;
  localparam logic [31:0] NOM_WIDTH_MAX    = 32'h0000_0314;

endpackage

// File: rtl/laser_tick_div.sv
// Timebase divider: free-running 0..TICK_DIV-1 counter with a synchronous
// restart so a new run starts on a full tick boundary.
module laser_tick_div
  import laser_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
    end else if (restart || (tick_cnt == LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/laser_pulse_gen.sv
// Programmable laser pulse generator: emits W-tick high pulses every P ticks,
// in bursts or continuously, and drops to FAULT on any safety condition.
module laser_pulse_gen
  import laser_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             laser_ready,
  input  logic             fail_in,
  input  logic             clear_fault,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_period,
  input  logic [15:0]      burst_len,
  output logic             laser_pulse_out,
  output logic             busy,
  output logic             run_done,
  output logic             fault_stop,
  output logic             config_err,
  output logic [15:0]      pulse_index
);

  laser_state_t     state, state_nxt;
  logic [CNT_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] cfg_width, cfg_width_nxt;
  logic [CNT_W-1:0] cfg_period, cfg_period_nxt;
  logic [15:0]      cfg_burst, cfg_burst_nxt;
  logic [15:0]      index_nxt;
  logic             run_done_nxt;
  logic             config_err_nxt;
  logic             restart;
  logic             tick;

  logic             running;
  logic             fault_trig;
  logic             start_req;
  logic             cfg_ok;
  logic [CNT_W-1:0] high_last;
  logic [CNT_W-1:0] low_last;

  laser_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .rstn    (rstn),
    .restart (restart),
    .tick    (tick)
  );

  assign running    = (state == ST_HIGH) || (state == ST_LOW);
  assign fault_trig = fail_in || (!laser_ready && running);
  assign start_req  = enable && laser_ready && !fail_in && !fault_stop;
  assign cfg_ok     = (pulse_width != '0) && (pulse_period > pulse_width);
  assign high_last  = cfg_width - CNT_W'(1);
  assign low_last   = cfg_period - cfg_width - CNT_W'(1);

  // Fault entry overrides every other transition; a HIGH phase is never cut
  // short by enable, only by a safety condition.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    cfg_width_nxt  = cfg_width;
    cfg_period_nxt = cfg_period;
    cfg_burst_nxt  = cfg_burst;
    index_nxt      = pulse_index;
    run_done_nxt   = 1'b0;
    config_err_nxt = config_err;
    restart        = 1'b0;

    if (fault_trig) begin
      state_nxt = ST_FAULT;
      phase_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (cfg_ok) begin
              cfg_width_nxt  = pulse_width;
              cfg_period_nxt = pulse_period;
              cfg_burst_nxt  = burst_len;
              index_nxt      = 16'd1;
              config_err_nxt = 1'b0;
              phase_nxt      = '0;
              restart        = 1'b1;
              state_nxt      = ST_HIGH;
            end else begin
              config_err_nxt = 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (tick) begin
            if (phase == high_last) begin
              phase_nxt = '0;
              state_nxt = ST_LOW;
            end else begin
              phase_nxt = phase + CNT_W'(1);
            end
          end
        end

        ST_LOW: begin
          if (tick) begin
            if (phase == low_last) begin
              phase_nxt = '0;
              if ((cfg_burst != 16'd0) && (pulse_index == cfg_burst)) begin
                run_done_nxt = 1'b1;
                state_nxt    = ST_IDLE;
              end else if (!enable) begin
                run_done_nxt = 1'b1;
                state_nxt    = ST_IDLE;
              end else begin
                index_nxt = pulse_index + 16'd1;
                state_nxt = ST_HIGH;
              end
            end else begin
              phase_nxt = phase + CNT_W'(1);
            end
          end
        end

        ST_FAULT: begin
          if (clear_fault) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are registered from the next-state decode so they change
  // together with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      phase           <= '0;
      cfg_width       <= '0;
      cfg_period      <= '0;
      cfg_burst       <= '0;
      pulse_index     <= '0;
      laser_pulse_out <= 1'b0;
      busy            <= 1'b0;
      run_done        <= 1'b0;
      fault_stop      <= 1'b0;
      config_err      <= 1'b0;
    end else begin
      state           <= state_nxt;
      phase           <= phase_nxt;
      cfg_width       <= cfg_width_nxt;
      cfg_period      <= cfg_period_nxt;
      cfg_burst       <= cfg_burst_nxt;
      pulse_index     <= index_nxt;
      laser_pulse_out <= (state_nxt == ST_HIGH);
      busy            <= (state_nxt == ST_HIGH) || (state_nxt == ST_LOW);
      run_done        <= run_done_nxt;
      fault_stop      <= (state_nxt == ST_FAULT);
      config_err      <= config_err_nxt;
    end
  end

endmodule

// File: doc/laser_pulse_gen.md
Name: laser_pulse_gen

Overview:
- Programmable laser pulse generator: the transmit side of the laser pulse-width/rate safety monitor.
- Produces laser_pulse_out with configured high width and period, in single bursts or continuously.
- Timebase is a divided tick matching the monitor's clk/8 sampling.
- Stops immediately on any safety fail or loss of laser_ready; a fault is held until cleared.

Parameters:
- TICK_DIV, 8: clk cycles per timebase tick; must be ≥ 2.
- CNT_W, 32: width of the width/period counters.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- enable  input  1  level; run request
- laser_ready  input  1  laser driver ready; output is gated by it
- fail_in  input  1  OR of monitor fail flags (lower/upper/rate)
- clear_fault  input  1  level; releases FAULT
- pulse_width  input  CNT_W  high time in ticks
- pulse_period  input  CNT_W  rising-edge-to-rising-edge time in ticks
- burst_len  input  16  pulses per run; 0 = continuous
- laser_pulse_out  output  1  registered pulse to laser driver
- busy  output  1  state is HIGH or LOW
- run_done  output  1  one-clk strobe when a burst completes or a stop request finishes
- fault_stop  output  1  high while in FAULT
- config_err  output  1  sticky; set on invalid config at start
- pulse_index  output  16  pulses emitted in the current run

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Tick counter, phase counter and latched config all 0.
- Timebase:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick = (tick_cnt == TICK_DIV-1).
  - tick_cnt is forced to 0 on entry to HIGH from IDLE.
- States: IDLE, HIGH, LOW, FAULT.
- IDLE, start condition: start when enable & laser_ready & !fail_in & !fault_stop.
- IDLE, config check on start:
  - Config is valid when pulse_width ≥ 1 and pulse_period > pulse_width.
  - Valid: latch pulse_width, pulse_period and burst_len; set pulse_index = 1; go to HIGH. laser_pulse_out is 1 on the next clk.
  - Invalid: set config_err and stay in IDLE.
  - config_err clears only on a valid start or on reset.
- Config stability: latched values are used for the whole run; input changes mid-run are ignored.
- HIGH:
  - laser_pulse_out = 1.
  - phase increments on each tick.
  - On tick with phase == W-1: phase ← 0, go to LOW.
  - High time is exactly W·TICK_DIV clk.
- LOW:
  - laser_pulse_out = 0.
  - On tick with phase == P-W-1: phase ← 0, then:
    - If burst_len ≠ 0 and pulse_index == burst_len: run_done strobe, go to IDLE.
    - Else if enable == 0: run_done strobe, go to IDLE.
    - Else: pulse_index + 1 (wraps at 16 bits), go to HIGH.
  - Rising-edge spacing is exactly P·TICK_DIV clk.
- Enable dropped mid-run:
  - Never truncate a HIGH phase; a short pulse would itself trip the monitor's lower limit.
  - The current LOW phase is also completed, so the last period is full length before IDLE.
- Fault entry (priority over all other transitions, any state):
  - Trigger: fail_in = 1, or laser_ready = 0 while busy.
  - Next clk: laser_pulse_out = 0, fault_stop = 1, state FAULT, phase ← 0. No run_done.
- FAULT exit: when clear_fault & !fail_in, go to IDLE and drop fault_stop. A new start needs enable and follows the normal start rules.
- Simultaneous events:
  - fail_in on the same clk as a start: FAULT wins; no pulse is emitted.
  - clear_fault while fail_in is still high: ignored.
- busy = (state == HIGH || state == LOW), registered.
- pulse_index holds its last value in IDLE/FAULT and resets to 1 on each start.

Decomposition:
- Shared package laser_pkg holds:
  - State encodings (IDLE/HIGH/LOW/FAULT).
  - TICK_DIV default (8).
  - Nominal timing constants shared with the monitor: 25 ms period = 0x01312D ticks; nominal width limits 0x307/0x314.
- One sub-module, laser_tick_div: tick counter with synchronous restart input; output tick.

Test Plan:
- TICK_DIV=8, W=4, P=10, burst=3, enable held:
  - 3 pulses, each high 32 clk, rising edges 80 clk apart.
  - run_done one clk after the third LOW phase ends; pulse_index = 3.
- burst=0, W=2, P=5: continuous output. Drop enable at clk 100 (mid-HIGH):
  - That pulse still lasts its full 16 clk, and the LOW phase its full 24 clk.
  - Then IDLE and run_done; no further edges.
- W=4, P=10, continuous: assert fail_in during HIGH:
  - laser_pulse_out = 0 on the next clk; fault_stop = 1; busy = 0.
  - clear_fault while fail_in = 1 has no effect.
  - After fail_in = 0 and clear_fault: IDLE, fault_stop = 0.
- Deassert laser_ready during LOW: FAULT on the next clk; no rising edge occurs afterwards.
- Invalid config:
  - W=0, P=10, enable=1: config_err = 1, output stays 0, busy = 0.
  - Then W=3, P=3: still rejected.
  - Then W=3, P=4: config_err clears and a 24-clk high pulse follows.
- Assert rstn low mid-HIGH:
  - All outputs 0 immediately (asynchronous).
  - After release, start again; first pulse width is exact (tick counter restarted).
